// File: rtl/otter_iobus_responder.sv
// otter_iobus_responder: Otter IOBUS peripheral window (switches, buttons, LEDs, seven-segment, IRQ).
// Define OTTER_IO_TIMER_EN to build the down-counting timer (TCTRL/TLOAD/TCOUNT, IRQ_STAT[0]).
module otter_iobus_responder #(
   parameter logic [31:0] BASE_ADDR      = 32'h1100_0000,
   parameter int          TIMER_PRESCALE = 1,
   parameter int          SW_WIDTH       = 16,
   parameter int          BTN_WIDTH      = 5,
   parameter int          LED_WIDTH      = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [31:0]          IOBUS_ADDR,
   input  logic [31:0]          IOBUS_OUT,
   input  logic                 IOBUS_WR,
   output logic [31:0]          IOBUS_IN,
   output logic                 INTR,
   input  logic [SW_WIDTH-1:0]  SWITCHES,
   input  logic [BTN_WIDTH-1:0] BUTTONS,
   output logic [LED_WIDTH-1:0] LEDS,
   output logic [15:0]          SSEG
);
   localparam logic [7:0] OFF_SW    = 8'h00;
   localparam logic [7:0] OFF_BTN   = 8'h04;
   localparam logic [7:0] OFF_LED   = 8'h20;
   localparam logic [7:0] OFF_SSEG  = 8'h40;
   localparam logic [7:0] OFF_TCTRL = 8'h80;
   localparam logic [7:0] OFF_TLOAD = 8'h84;
   localparam logic [7:0] OFF_TCNT  = 8'h88;
   localparam logic [7:0] OFF_STAT  = 8'h8C;
   localparam logic [7:0] OFF_MASK  = 8'h90;

   logic                 hit, wr;
   logic [7:0]           off;
   logic [SW_WIDTH-1:0]  sw_s1_q, sw_s2_q;
   logic [BTN_WIDTH-1:0] btn_s1_q, btn_s2_q, btn_prev_q;
   logic [LED_WIDTH-1:0] led_q, led_d;
   logic [15:0]          sseg_q, sseg_d;
   logic [1:0]           stat_q, stat_d, mask_q, mask_d, irq_set, irq_clr;
   logic [31:0]          rd_d, rd_q, tmr_rd;
   logic                 intr_q, btn_rise, tmr_evt, unused;

   assign hit      = IOBUS_ADDR[31:8] == BASE_ADDR[31:8];
   assign off      = {IOBUS_ADDR[7:2], 2'b00};
   assign wr       = IOBUS_WR && hit;
   assign btn_rise = |(btn_s2_q & ~btn_prev_q);
   assign unused   = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

`ifdef OTTER_IO_TIMER_EN
   localparam logic [1:0] IRQ_BITS = 2'b11;
   localparam int PW = $clog2(TIMER_PRESCALE + 1);

   logic          en_q, en_d, arl_q, arl_d, tick;
   logic [31:0]   tload_q, tload_d, tcount_q, tcount_d;
   logic [PW-1:0] pre_q, pre_d;

   // Register writes are applied after the tick so software always wins over the timer.
   always_comb begin
      tick     = en_q && (pre_q == PW'(TIMER_PRESCALE - 1));
      pre_d    = (!en_q || tick) ? '0 : pre_q + PW'(1);
      tmr_evt  = tick && (tcount_q == '0);
      en_d     = (tmr_evt && !arl_q) ? 1'b0 : en_q;
      arl_d    = arl_q;
      tload_d  = tload_q;
      tcount_d = tmr_evt ? (arl_q ? tload_q : '0) : tick ? tcount_q - 32'd1 : tcount_q;
      if (wr && off == OFF_TCTRL) begin
         en_d  = IOBUS_OUT[0];
         arl_d = IOBUS_OUT[1];
      end
      if (wr && off == OFF_TLOAD) begin
         tload_d  = IOBUS_OUT;
         tcount_d = IOBUS_OUT;
      end
      tmr_rd = off == OFF_TCTRL ? {30'd0, arl_q, en_q} :
               off == OFF_TLOAD ? tload_q :
               off == OFF_TCNT  ? tcount_q : '0;
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         en_q     <= 1'b0;
         arl_q    <= 1'b0;
         tload_q  <= '0;
         tcount_q <= '0;
         pre_q    <= '0;
      end else begin
         en_q     <= en_d;
         arl_q    <= arl_d;
         tload_q  <= tload_d;
         tcount_q <= tcount_d;
         pre_q    <= pre_d;
      end
`else
   localparam logic [1:0] IRQ_BITS = 2'b10;

   assign tmr_evt = 1'b0;
   assign tmr_rd  = '0;
`endif

   // Set is OR'd in after the W1C clear so a same-edge event is never lost.
   always_comb begin
      led_d   = (wr && off == OFF_LED) ? IOBUS_OUT[LED_WIDTH-1:0] : led_q;
      sseg_d  = (wr && off == OFF_SSEG) ? IOBUS_OUT[15:0] : sseg_q;
      mask_d  = (wr && off == OFF_MASK) ? IOBUS_OUT[1:0] & IRQ_BITS : mask_q;
      irq_clr = (wr && off == OFF_STAT) ? IOBUS_OUT[1:0] : 2'b00;
      irq_set = {btn_rise, tmr_evt};
      stat_d  = ((stat_q & ~irq_clr) | irq_set) & IRQ_BITS;
      rd_d    = !hit              ? '0 :
                off == OFF_SW     ? 32'(sw_s2_q) :
                off == OFF_BTN    ? 32'(btn_s2_q) :
                off == OFF_LED    ? 32'(led_q) :
                off == OFF_SSEG   ? {16'd0, sseg_q} :
                off == OFF_STAT   ? {30'd0, stat_q} :
                off == OFF_MASK   ? {30'd0, mask_q} : tmr_rd;
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_prev_q <= '0;
         led_q      <= '0;
         sseg_q     <= '0;
         stat_q     <= '0;
         mask_q     <= '0;
         rd_q       <= '0;
         intr_q     <= 1'b0;
      end else begin
         sw_s1_q    <= SWITCHES;
         sw_s2_q    <= sw_s1_q;
         btn_s1_q   <= BUTTONS;
         btn_s2_q   <= btn_s1_q;
         btn_prev_q <= btn_s2_q;
         led_q      <= led_d;
         sseg_q     <= sseg_d;
         stat_q     <= stat_d;
         mask_q     <= mask_d;
         rd_q       <= rd_d;
         intr_q     <= |(stat_q & mask_q);
      end

   assign IOBUS_IN = rd_q;
   assign INTR     = intr_q;
   assign LEDS     = led_q;
   assign SSEG     = sseg_q;
endmodule

// File: tb/tb_otter_iobus_responder.sv
// tb_otter_iobus_responder: scoreboard bench for the Otter IOBUS responder.
// Timer checks are built when OTTER_IO_TIMER_EN is defined; otherwise the timer-absent behaviour is checked.
module tb_otter_iobus_responder;
   logic        CLK = 1'b0, RST_N = 1'b1, IOBUS_WR = 1'b0, INTR;
   logic [31:0] IOBUS_ADDR = '0, IOBUS_OUT = '0, IOBUS_IN;
   logic [15:0] SWITCHES = '0, LEDS, SSEG;
   logic [4:0]  BUTTONS = '0;
   int          checks = 0, failures = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   localparam logic [31:0] B = 32'h1100_0000;
`ifdef OTTER_IO_TIMER_EN
   localparam logic [31:0] MSK = 32'h3;
`else
   localparam logic [31:0] MSK = 32'h2;
`endif

   always #5 CLK = ~CLK;

   otter_iobus_responder dut (
      .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
      .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .INTR(INTR), .SWITCHES(SWITCHES),
      .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG(SSEG)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      IOBUS_WR   = 1'b1;
      step();
      IOBUS_WR   = 1'b0;
   endtask

   task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      IOBUS_ADDR = a;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      step();
      chk(tag_q.pop_front(), IOBUS_IN, exp_q.pop_front());
   endtask

   initial begin
      #2 RST_N = 1'b0;
      step();
      step();
      chk("rst_iobus_in", IOBUS_IN, 0);
      chk("rst_intr", 32'(INTR), 0);
      chk("rst_leds", 32'(LEDS), 0);
      chk("rst_sseg", 32'(SSEG), 0);
      RST_N = 1'b1;
      step();

      bus_wr(B + 32'h20, 32'h0000_A5A5);
      chk("led_store", 32'(LEDS), 32'hA5A5);
      bus_rd("led_load", B + 32'h20, 32'h0000_A5A5);
      bus_wr(32'h1200_0020, 32'h0000_1234);
      chk("led_miss_store", 32'(LEDS), 32'hA5A5);
      bus_rd("led_low_bits_ignored", B + 32'h23, 32'h0000_A5A5);
      bus_rd("miss_load", 32'h1200_0020, 0);
      bus_wr(B + 32'h40, 32'hDEAD_BEEF);
      chk("sseg_store", 32'(SSEG), 32'hBEEF);
      bus_rd("sseg_load", B + 32'h40, 32'h0000_BEEF);
      bus_rd("unmapped_load", B + 32'h10, 0);

      SWITCHES = 16'h5A5A;
      step();
      step();
      bus_rd("sw_load", B, 32'h5A5A);
      bus_wr(B, 32'hFFFF_FFFF);
      bus_rd("sw_ro", B, 32'h5A5A);

      bus_wr(B + 32'h90, 32'h2);
      bus_rd("mask_load", B + 32'h90, 32'h2);
      BUTTONS = 5'h04;
      step();
      step();
      chk("btn_intr_e2", 32'(INTR), 0);
      step();
      chk("btn_intr_e3", 32'(INTR), 0);
      step();
      chk("btn_intr_e4", 32'(INTR), 1);
      bus_rd("btn_load", B + 32'h04, 32'h04);
      bus_rd("btn_stat", B + 32'h8C, 32'h2);
      bus_rd("btn_stat_again", B + 32'h8C, 32'h2);
      bus_wr(B + 32'h8C, 32'h2);
      chk("w1c_intr_same", 32'(INTR), 1);
      step();
      chk("w1c_intr_low", 32'(INTR), 0);
      bus_rd("btn_stat_cleared", B + 32'h8C, 0);
      repeat (3) step();
      chk("btn_held_no_retrig", 32'(INTR), 0);
      bus_wr(B + 32'h90, 32'h3);
      bus_rd("mask_width", B + 32'h90, MSK);
      bus_wr(B + 32'h90, 32'h2);

`ifdef OTTER_IO_TIMER_EN
      bus_wr(B + 32'h90, 32'h1);
      bus_wr(B + 32'h84, 32'd3);
      bus_wr(B + 32'h80, 32'h1);
      repeat (4) step();
      chk("os_intr_e4", 32'(INTR), 0);
      step();
      chk("os_intr_e5", 32'(INTR), 1);
      bus_rd("os_tctrl", B + 32'h80, 0);
      bus_rd("os_tcount", B + 32'h88, 0);
      bus_rd("os_stat", B + 32'h8C, 32'h1);
      bus_wr(B + 32'h8C, 32'h1);
      chk("os_w1c_intr_same", 32'(INTR), 1);
      step();
      chk("os_w1c_intr_low", 32'(INTR), 0);

      bus_wr(B + 32'h84, 32'd2);
      bus_wr(B + 32'h80, 32'h3);
      step();
      step();
      bus_wr(B + 32'h8C, 32'h1);
      bus_rd("ar_set_wins", B + 32'h8C, 32'h1);
      chk("ar_intr", 32'(INTR), 1);
      bus_wr(B + 32'h8C, 32'h1);
      bus_rd("ar_cleared", B + 32'h8C, 0);
      bus_rd("ar_next_event", B + 32'h8C, 32'h1);
      bus_rd("ar_reload", B + 32'h88, 32'd1);
      bus_rd("ar_tload", B + 32'h84, 32'd2);
      bus_wr(B + 32'h80, 32'h0);
      bus_wr(B + 32'h8C, 32'h1);
      bus_wr(B + 32'h90, 32'h2);
`else
      bus_wr(B + 32'h80, 32'h7);
      bus_rd("nt_tctrl", B + 32'h80, 0);
      bus_wr(B + 32'h84, 32'd5);
      bus_rd("nt_tload", B + 32'h84, 0);
      bus_rd("nt_tcount", B + 32'h88, 0);
      begin
         int highs = 0;
         bus_wr(B + 32'h90, 32'h3);
         bus_wr(B + 32'h84, 32'd0);
         repeat (12) begin
            step();
            if (INTR) highs++;
         end
         chk("nt_no_timer_intr", 32'(highs), 0);
         bus_rd("nt_stat", B + 32'h8C, 0);
         bus_wr(B + 32'h90, 32'h2);
      end
`endif

      BUTTONS = '0;
      repeat (3) step();
      BUTTONS = 5'h04;
      repeat (4) step();
      chk("intr_pre_rst", 32'(INTR), 1);
      bus_wr(B + 32'h84, 32'd5);
      bus_wr(B + 32'h80, 32'h1);
      bus_rd("pre_rst_led", B + 32'h20, 32'h0000_A5A5);
      #3 RST_N = 1'b0;
      #1;
      chk("mid_rst_iobus_in", IOBUS_IN, 0);
      chk("mid_rst_intr", 32'(INTR), 0);
      chk("mid_rst_leds", 32'(LEDS), 0);
      chk("mid_rst_sseg", 32'(SSEG), 0);
      BUTTONS = '0;
      step();
      RST_N = 1'b1;
      bus_rd("post_rst_tcount", B + 32'h88, 0);
      bus_rd("post_rst_tctrl", B + 32'h80, 0);
      bus_rd("post_rst_stat", B + 32'h8C, 0);
      bus_rd("post_rst_mask", B + 32'h90, 0);
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
